// File: rtl/sine_pkg.sv
// Shared constants and helpers for the sine frequency meter: FSM state codes,
// midpoint / divider-width derivations and the delta saturation value.
package sine_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_COUNT = 1'b1;

    function automatic int mid_code(input int dw);
        return 2 ** (dw - 1);
    endfunction

    // Numerator width for CYC * 2^PW plus the rounding half-count.
    function automatic int num_width(input int pw, input int cyc);
        return pw + $clog2(cyc) + 1;
    endfunction

    function automatic int sat_code(input int pw);
        return (2 ** pw) - 1;
    endfunction

endpackage

// File: rtl/sine_freq_meter_if.sv
// Sample-in / measurement-out bundle of the sine frequency meter.
interface sine_freq_meter_if
    import sine_pkg::*;
#(
    parameter int DW    = 12,
    parameter int PW    = 12,
    parameter int CNT_W = 24
);
    // Handshake: din is taken on any clk edge where din_valid=1; there is no
    // ready, the meter always accepts. meas_valid and timeout are one-cycle
    // strobes with no backpressure; delta_est/period_cnt/locked are levels.
    logic             din_valid;
    logic [DW-1:0]    din;
    logic [PW-1:0]    delta_est;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             locked;
    logic             timeout;
    state_t           state;

    modport master (
        output din_valid, din,
        input  delta_est, period_cnt, meas_valid, locked, timeout, state
    );

    modport slave (
        input  din_valid, din,
        output delta_est, period_cnt, meas_valid, locked, timeout, state
    );

endinterface

// File: rtl/udiv_seq.sv
// Sequential restoring divider: one quotient bit per clk, N_W clks from start
// to done. done is a one-cycle pulse with quo valid in that cycle.
module udiv_seq #(
    parameter int N_W = 17,
    parameter int D_W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] num,
    input  logic [D_W-1:0] den,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quo
);
    localparam int S_W = $clog2(N_W + 1);

    logic [N_W-1:0] q_r;
    logic [D_W-1:0] rem_r;
    logic [D_W-1:0] den_r;
    logic [S_W-1:0] step_r;
    logic [D_W:0]   trial;
    logic [D_W:0]   diff;
    logic           ge;

    // q_r shifts numerator bits out of the top while quotient bits enter below.
    always_comb begin
        trial = {rem_r, q_r[N_W-1]};
        diff  = trial - {1'b0, den_r};
        ge    = trial >= {1'b0, den_r};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r    <= '0;
            rem_r  <= '0;
            den_r  <= '0;
            step_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q_r    <= num;
                rem_r  <= '0;
                den_r  <= den;
                step_r <= S_W'(N_W);
                busy   <= 1'b1;
            end else if (busy) begin
                q_r    <= {q_r[N_W-2:0], ge};
                rem_r  <= ge ? diff[D_W-1:0] : trial[D_W-1:0];
                step_r <= step_r - S_W'(1);
                if (step_r == S_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quo = q_r;

endmodule

// File: rtl/sine_freq_meter.sv
// Estimates the DDS phase increment of a sampled sine: hysteretic rising
// crossings delimit CYC-period windows whose sample count is divided into CYC*2^PW.
module sine_freq_meter
    import sine_pkg::*;
#(
    parameter int DW    = 12,
    parameter int PW    = 12,
    parameter int CYC   = 16,
    parameter int HYST  = 64,
    parameter int CNT_W = 24
) (
    input logic              clk,
    input logic              rst,
    sine_freq_meter_if.slave bus
);
    localparam int NUM_W = num_width(PW, CYC);
    localparam int SUM_W = ((NUM_W > CNT_W) ? NUM_W : CNT_W) + 1;
    localparam int PER_W = $clog2(CYC);

    localparam logic [DW-1:0]    HI_THR   = DW'(mid_code(DW) + HYST);
    localparam logic [DW-1:0]    LO_THR   = DW'(mid_code(DW) - HYST);
    localparam logic [SUM_W-1:0] NUM_BASE = SUM_W'(CYC) << PW;
    localparam logic [SUM_W-1:0] NUM_MAX  = {{(SUM_W - NUM_W){1'b0}}, {NUM_W{1'b1}}};
    localparam logic [NUM_W-1:0] SAT_Q    = NUM_W'(sat_code(PW));
    localparam logic [PER_W-1:0] LAST_PER = PER_W'(CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_r;
    logic             pol_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] pend_cnt_r;
    logic [PER_W-1:0] per_r;
    logic             lock_ok_r;
    logic [PW-1:0]    delta_r;
    logic [CNT_W-1:0] period_r;
    logic             meas_valid_r;
    logic             locked_r;
    logic             timeout_r;

    logic             above;
    logic             below;
    logic             rising;
    logic             win_end;
    logic             sat_hit;
    logic [SUM_W-1:0] num_sum;
    logic [NUM_W-1:0] div_num;
    logic [NUM_W-1:0] div_quo;
    logic             div_busy;
    logic             div_done;
    logic [PW-1:0]    delta_next;

    always_comb begin
        above      = bus.din >= HI_THR;
        below      = bus.din < LO_THR;
        rising     = bus.din_valid && !pol_r && above;
        cnt_inc    = cnt_r + CNT_W'(1);
        win_end    = (state_r == ST_COUNT) && rising && (per_r == LAST_PER);
        sat_hit    = (state_r == ST_COUNT) && bus.din_valid && !win_end && (cnt_inc == CNT_MAX);
        // Counts too large for the numerator clamp it; the quotient is 0 there anyway.
        num_sum    = NUM_BASE + SUM_W'(cnt_inc >> 1);
        div_num    = (num_sum > NUM_MAX) ? '1 : num_sum[NUM_W-1:0];
        delta_next = (div_quo > SAT_Q) ? PW'(SAT_Q) : div_quo[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            pol_r        <= 1'b0;
            cnt_r        <= '0;
            pend_cnt_r   <= '0;
            per_r        <= '0;
            lock_ok_r    <= 1'b0;
            delta_r      <= '0;
            period_r     <= '0;
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            meas_valid_r <= div_done;
            timeout_r    <= 1'b0;
            if (div_done) begin
                delta_r  <= delta_next;
                period_r <= pend_cnt_r;
                if (lock_ok_r) locked_r <= 1'b1;
            end
            if (bus.din_valid) begin
                if (above)      pol_r <= 1'b1;
                else if (below) pol_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rising) begin
                        cnt_r   <= '0;
                        per_r   <= '0;
                        state_r <= ST_COUNT;
                    end
                end
                default: begin
                    if (bus.din_valid) begin
                        // Window end takes priority over saturation on the same sample.
                        if (win_end) begin
                            cnt_r      <= '0;
                            per_r      <= '0;
                            pend_cnt_r <= cnt_inc;
                            lock_ok_r  <= 1'b1;
                        end else if (sat_hit) begin
                            cnt_r     <= '0;
                            per_r     <= '0;
                            state_r   <= ST_IDLE;
                            timeout_r <= 1'b1;
                            locked_r  <= 1'b0;
                            lock_ok_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_inc;
                            if (rising) per_r <= per_r + PER_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    udiv_seq #(
        .N_W(NUM_W),
        .D_W(CNT_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .start(win_end),
        .num  (div_num),
        .den  (cnt_inc),
        .busy (div_busy),
        .done (div_done),
        .quo  (div_quo)
    );

    // A window shorter than the divide latency would overwrite an in-flight divide.
    assert property (@(posedge clk) disable iff (!rst) !(win_end && div_busy));

    assign bus.delta_est  = delta_r;
    assign bus.period_cnt = period_r;
    assign bus.meas_valid = meas_valid_r;
    assign bus.locked     = locked_r;
    assign bus.timeout    = timeout_r;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Bench for sine_freq_meter: DDS-style sine / noise / grazing stimulus, a
// sample-index reference model feeding an expected queue, and a cycle monitor.
module tb_sine_freq_meter;
    localparam int DW    = 12;
    localparam int PW    = 12;
    localparam int CYC   = 16;
    localparam int HYST  = 64;
    localparam int CNT_W = 12;
    localparam int MID   = 2048;
    localparam int HI    = MID + HYST;
    localparam int LO    = MID - HYST;
    localparam int LAT   = PW + $clog2(CYC) + 2;
    localparam int EXP_W = 32 + 1 + PW + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_to = 0;

    sine_freq_meter_if #(.DW(DW), .PW(PW), .CNT_W(CNT_W)) bus ();

    sine_freq_meter #(
        .DW(DW), .PW(PW), .CYC(CYC), .HYST(HYST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {due cycle, is_timeout, delta, count}
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    // Reference model state, in terms of accepted-sample indices.
    bit m_pol;
    bit m_meas;
    int m_idx;
    int m_start;
    int m_cross;
    int m_last_delta;
    int m_last_cnt;
    int dds_ph;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_delta(input int c);
        int q;
        q = (CYC * (2 ** PW) + c / 2) / c;
        return (q > (2 ** PW) - 1) ? (2 ** PW) - 1 : q;
    endfunction

    function automatic logic [DW-1:0] sine_at(input int ph);
        real v;
        v = 2048.0 + 2047.0 * $sin(6.283185307179586 * ph / 4096.0);
        return DW'($rtoi(v + 0.5));
    endfunction

    task automatic model_reset();
        m_pol = 0; m_meas = 0; m_idx = 0; m_start = 0; m_cross = 0;
        m_last_delta = 0; m_last_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int d, input int acc);
        bit rising;
        int cnt;
        rising = 0;
        if (d >= HI) begin
            rising = !m_pol;
            m_pol = 1;
        end else if (d < LO) begin
            m_pol = 0;
        end
        if (!m_meas) begin
            if (rising) begin
                m_meas = 1; m_start = m_idx; m_cross = 0;
            end
        end else begin
            if (rising) m_cross++;
            if (rising && m_cross == CYC) begin
                cnt = m_idx - m_start;
                m_last_delta = exp_delta(cnt);
                m_last_cnt = cnt;
                exp_q.push_back({32'(acc + LAT), 1'b0, PW'(m_last_delta), CNT_W'(cnt)});
                m_start = m_idx; m_cross = 0;
            end else if (m_idx - m_start == (2 ** CNT_W) - 1) begin
                exp_q.push_back({32'(acc), 1'b1, PW'(m_last_delta), CNT_W'(m_last_cnt)});
                m_meas = 0;
            end
        end
        m_idx++;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        bus.din_valid = v;
        bus.din = d;
        if (v) model_accept(int'(d), cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, DW'($urandom_range(0, 4095)));
    endtask

    task automatic run_sine(input int delta, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, sine_at(dds_ph));
            dds_ph = (dds_ph + delta) % 4096;
            for (int g = 0; g < gap; g++) drive(1'b0, DW'($urandom_range(0, 4095)));
        end
    endtask

    // Each period: clean high, graze inside the band, clean low, graze again.
    task automatic run_graze(input int periods);
        for (int p = 0; p < periods; p++) begin
            drive(1'b1, DW'(HI));
            for (int i = 0; i < 7; i++) drive(1'b1, DW'($urandom_range(HI, 4095)));
            drive(1'b1, DW'(HI - 1));
            for (int i = 0; i < 19; i++) drive(1'b1, DW'($urandom_range(LO, HI - 1)));
            drive(1'b1, DW'(LO - 1));
            for (int i = 0; i < 7; i++) drive(1'b1, DW'($urandom_range(0, LO - 1)));
            drive(1'b1, DW'(LO));
            for (int i = 0; i < 19; i++) drive(1'b1, DW'($urandom_range(LO, HI - 1)));
        end
    endtask

    task automatic run_noise(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, DW'(MID - 40 + int'($urandom_range(0, 80))));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_delta_est"}, bus.delta_est, 0);
        check({tag, "_period_cnt"}, bus.period_cnt, 0);
        check({tag, "_locked"}, bus.locked, 0);
        check({tag, "_meas_valid"}, bus.meas_valid, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic phase_check(input string tag, input int want_cnt, input int want_delta);
        idle(LAT + 4);
        check({tag, "_period_cnt"}, bus.period_cnt, want_cnt);
        check({tag, "_delta_est"}, bus.delta_est, want_delta);
        check({tag, "_locked"}, bus.locked, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.meas_valid || bus.timeout) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {bus.meas_valid, bus.timeout}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_cycle", cyc, mon_e[EXP_W-1 -: 32]);
                    check("meas_valid", bus.meas_valid, !mon_e[PW+CNT_W]);
                    check("timeout", bus.timeout, mon_e[PW+CNT_W]);
                    check("delta_est", bus.delta_est, mon_e[CNT_W +: PW]);
                    check("period_cnt", bus.period_cnt, mon_e[CNT_W-1:0]);
                    check("locked", bus.locked, !mon_e[PW+CNT_W]);
                    if (bus.timeout) n_to++;
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) < cyc) begin
                mon_e = exp_q.pop_front();
                check("missing_output", cyc, mon_e[EXP_W-1 -: 32]);
            end
        end
    end

    initial begin
        int n;
        bit in_range;
        bus.din_valid = 1'b0;
        bus.din = '0;
        model_reset();
        dds_ph = int'($urandom_range(0, 4095));

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_state", bus.state, sine_pkg::ST_IDLE);
        rst = 1'b1;

        run_sine(64, 5000, 0);
        phase_check("d64", 1024, 64);

        run_sine(100, 3000, 0);
        idle(LAT + 4);
        in_range = (bus.period_cnt == 655 || bus.period_cnt == 656) &&
                   (bus.delta_est >= 99 && bus.delta_est <= 101);
        check("d100_range", in_range, 1);

        dds_ph = 1024;
        run_sine(2048, 300, 0);
        phase_check("d2048", 32, 2048);

        run_sine(64, 4000, 2);
        phase_check("d64_sparse", 1024, 64);

        run_graze(50);
        phase_check("graze", 896, exp_delta(896));

        run_sine(64, 3000, 0);
        run_noise(4300);
        idle(4);
        check("to_count", n_to, 1);
        check("to_locked", bus.locked, 0);
        check("to_state", bus.state, sine_pkg::ST_IDLE);
        check("to_delta_hold", bus.delta_est, 64);
        check("to_cnt_hold", bus.period_cnt, 1024);

        n = 0;
        while (exp_q.size() == 0 && n < 3000) begin
            run_sine(64, 1, 0);
            n++;
        end
        check("window_before_reset", exp_q.size() > 0, 1);
        run_sine(64, 5, 0);
        apply_reset();
        run_sine(64, 3000, 0);
        phase_check("after_rst", 1024, 64);

        idle(LAT + 4);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
